// File: rtl/copro_pkg.sv
// Shared types and constants for the custom-0 coprocessor issue controller.
package copro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [6:0] CUSTOM0_OP = 7'b0001011;

    localparam logic [2:0] FN_GCD = 3'd0;
    localparam logic [2:0] FN_LCM = 3'd1;

    // Wide enough to hold TIMEOUT_CYCLES itself without wrapping.
    function automatic int unsigned ctr_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

endpackage

// File: rtl/copro_timeout_ctr.sv
// Saturating WAIT-cycle counter; expired flags the final allowed WAIT cycle.
module copro_timeout_ctr
    import copro_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = ctr_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/copro_issue_ctrl.sv
// Multi-cycle issue controller: accepts one custom-0 instruction, starts the
// selected unit, stalls the front-end until done/timeout, then writes back once.
module copro_issue_ctrl
    import copro_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_UNITS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [6:0]  CUSTOM_OP      = CUSTOM0_OP
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    input  logic [6:0]                op,
    input  logic [2:0]                funct3,
    input  logic [4:0]                rd,
    input  logic [XLEN-1:0]           rs1_val,
    input  logic [XLEN-1:0]           rs2_val,
    output logic [NUM_UNITS-1:0]      start,
    output logic [XLEN-1:0]           unit_a,
    output logic [XLEN-1:0]           unit_b,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [NUM_UNITS*XLEN-1:0] unit_result,
    output logic                      stall,
    output logic                      wb_en,
    output logic [4:0]                wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic                      err_illegal,
    output logic                      err_timeout,
    output logic                      busy
);

    localparam logic [3:0] NUM_UNITS_W = 4'(NUM_UNITS);

    state_t                state;
    logic [2:0]            sel_q;
    logic [4:0]            rd_q;
    logic                  match;
    logic                  legal;
    logic                  done_sel;
    logic [XLEN-1:0]       res_sel;
    logic [NUM_UNITS-1:0]  start_onehot;
    logic                  expired;

    assign match = instr_valid && (op == CUSTOM_OP);
    assign legal = ({1'b0, funct3} < NUM_UNITS_W);

    // Stall asserts in the accept cycle itself so PC does not advance past the instruction.
    assign stall = (state == ISSUE) || (state == WAIT) || ((state == IDLE) && match && legal);
    assign busy  = (state != IDLE);

    // Route only the selected unit's done/result; other units' done bits are ignored.
    always_comb begin
        done_sel = 1'b0;
        res_sel  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (sel_q == 3'(k)) begin
                done_sel = unit_done[k];
                res_sel  = unit_result[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        start_onehot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            start_onehot[k] = (funct3 == 3'(k));
        end
    end

    copro_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == ISSUE),
        .en     (state == WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel_q       <= '0;
            rd_q        <= '0;
            start       <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            wb_en       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            start       <= '0;
            wb_en       <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (match && legal) begin
                        unit_a <= rs1_val;
                        unit_b <= rs2_val;
                        rd_q   <= rd;
                        sel_q  <= funct3;
                        start  <= start_onehot;
                        state  <= ISSUE;
                    end else if (match) begin
                        err_illegal <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Done takes priority over a timeout landing on the same cycle.
                    if (done_sel) begin
                        wb_data <= res_sel;
                        wb_rd   <= rd_q;
                        wb_en   <= (rd_q != 5'd0);
                        state   <= WB;
                    end else if (expired) begin
                        wb_data     <= '0;
                        wb_rd       <= rd_q;
                        wb_en       <= (rd_q != 5'd0);
                        err_timeout <= 1'b1;
                        state       <= WB;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_copro_issue_ctrl.sv
// Directed self-checking bench for copro_issue_ctrl (NUM_UNITS=2, TIMEOUT_CYCLES=8).
module tb_copro_issue_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NU   = 2;
    localparam int unsigned TO   = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            instr_valid = 1'b0;
    logic [6:0]      op = 7'd0;
    logic [2:0]      funct3 = 3'd0;
    logic [4:0]      rd = 5'd0;
    logic [XLEN-1:0] rs1_val = '0;
    logic [XLEN-1:0] rs2_val = '0;
    logic [NU-1:0]   start;
    logic [XLEN-1:0] unit_a;
    logic [XLEN-1:0] unit_b;
    logic [NU-1:0]   unit_done = '0;
    logic [NU*XLEN-1:0] unit_result = '0;
    logic            stall;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            err_illegal;
    logic            err_timeout;
    logic            busy;

    int checks = 0;
    int errors = 0;

    copro_issue_ctrl #(
        .XLEN(XLEN), .NUM_UNITS(NU), .TIMEOUT_CYCLES(TO), .CUSTOM_OP(7'b0001011)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op),
        .funct3(funct3), .rd(rd), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .start(start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result),
        .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_illegal(err_illegal), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a custom-0 instruction for one cycle, checking the combinational accept stall.
    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] d, input logic exp_stall);
        instr_valid = 1'b1;
        op          = 7'b0001011;
        funct3      = f3;
        rs1_val     = a;
        rs2_val     = b;
        rd          = d;
        #1;
        check("accept_stall", stall, exp_stall);
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #3;
        check("rst_start", start, 0);
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_unit_a", unit_a, 0);
        check("rst_wb_data", wb_data, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // GCD: done 4 cycles after start; a done during ISSUE must be ignored
        issue(3'd0, 32'd48, 32'd18, 5'd5, 1'b1);
        check("gcd_start", start, 2'b01);
        check("gcd_busy", busy, 1);
        check("gcd_unit_a", unit_a, 48);
        check("gcd_unit_b", unit_b, 18);
        unit_done = 2'b01;
        unit_result = {32'd0, 32'd77};
        tick();
        unit_done = 2'b00;
        check("gcd_start_1cyc", start, 0);
        check("gcd_issue_done_ignored", wb_en, 0);
        for (int i = 0; i < 3; i++) begin
            check("gcd_wait_stall", stall, 1);
            tick();
        end
        check("gcd_wait_stall", stall, 1);
        unit_done = 2'b01;
        unit_result = {32'd0, 32'd6};
        tick();
        unit_done = 2'b00;
        check("gcd_wb_en", wb_en, 1);
        check("gcd_wb_rd", wb_rd, 5);
        check("gcd_wb_data", wb_data, 6);
        check("gcd_wb_stall", stall, 0);
        check("gcd_wb_no_err", err_timeout, 0);
        tick();
        check("gcd_idle_wb_en", wb_en, 0);
        check("gcd_idle_busy", busy, 0);

        // LCM: stray unit0 done in WAIT ignored, unit1 result written back
        issue(3'd1, 32'd4, 32'd6, 5'd7, 1'b1);
        check("lcm_start", start, 2'b10);
        tick();
        unit_done = 2'b01;
        unit_result = {32'd0, 32'd99};
        tick();
        unit_done = 2'b00;
        check("lcm_stray_stall", stall, 1);
        check("lcm_stray_wb_en", wb_en, 0);
        unit_done = 2'b10;
        unit_result = {32'd12, 32'd99};
        tick();
        unit_done = 2'b00;
        check("lcm_wb_en", wb_en, 1);
        check("lcm_wb_data", wb_data, 12);
        check("lcm_wb_rd", wb_rd, 7);
        tick();

        // Illegal select
        issue(3'd3, 32'd1, 32'd2, 5'd4, 1'b0);
        check("ill_err", err_illegal, 1);
        check("ill_start", start, 0);
        check("ill_stall", stall, 0);
        check("ill_busy", busy, 0);
        tick();
        check("ill_err_pulse", err_illegal, 0);

        // Timeout: unit never answers
        issue(3'd0, 32'd3, 32'd5, 5'd9, 1'b1);
        tick();
        for (int i = 0; i < int'(TO) - 1; i++) begin
            check("to_wait_stall", stall, 1);
            check("to_wait_wb_en", wb_en, 0);
            tick();
        end
        check("to_last_stall", stall, 1);
        tick();
        check("to_wb_en", wb_en, 1);
        check("to_err", err_timeout, 1);
        check("to_wb_data", wb_data, 0);
        check("to_wb_rd", wb_rd, 9);
        check("to_wb_stall", stall, 0);
        tick();
        check("to_err_pulse", err_timeout, 0);
        check("to_idle_busy", busy, 0);

        // Done on the last WAIT cycle beats the timeout
        issue(3'd0, 32'd3, 32'd5, 5'd10, 1'b1);
        tick();
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        unit_done = 2'b01;
        unit_result = {32'd0, 32'h55};
        tick();
        unit_done = 2'b00;
        check("late_wb_en", wb_en, 1);
        check("late_no_err", err_timeout, 0);
        check("late_wb_data", wb_data, 32'h55);
        tick();

        // rd=x0: no write enable, data still driven; next instruction held through WB
        issue(3'd1, 32'd8, 32'd8, 5'd0, 1'b1);
        tick();
        unit_done = 2'b10;
        unit_result = {32'h33, 32'd0};
        tick();
        unit_done = 2'b00;
        check("x0_wb_en", wb_en, 0);
        check("x0_wb_data", wb_data, 32'h33);
        check("x0_busy", busy, 1);
        instr_valid = 1'b1;
        funct3 = 3'd0;
        rd = 5'd3;
        rs1_val = 32'd21;
        #1;
        check("wb_no_accept_stall", stall, 0);
        tick();
        check("wb_no_accept_start", start, 0);
        check("wb_no_accept_busy", busy, 0);
        check("next_accept_stall", stall, 1);
        tick();
        instr_valid = 1'b0;
        check("next_start", start, 2'b01);
        tick();
        tick();

        // Asynchronous reset mid-WAIT
        #2 reset = 1'b1;
        #1;
        check("arst_stall", stall, 0);
        check("arst_busy", busy, 0);
        check("arst_unit_a", unit_a, 0);
        check("arst_wb_data", wb_data, 0);
        check("arst_wb_rd", wb_rd, 0);
        #4 reset = 1'b0;
        unit_done = 2'b01;
        unit_result = {32'd0, 32'h44};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_no_wb", wb_en, 0);
        end
        check("arst_idle_busy", busy, 0);
        unit_done = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
